// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch path: opcode constants, the halt word and
// the fetch FSM state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [63:0] HALT_INSTR = '0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc_unit.sv
// Combinational next-PC selection: sequential pc+4 or PC-relative branch
// target, plus the alignment check on a taken target.
module next_pc_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  branch,
  input  logic                  zero,
  input  logic [ADDR_WIDTH-1:0] branch_imm,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  misaligned
);

  logic                  taken;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] seq_pc;

  // Immediate is in half-words; both sums wrap silently at ADDR_WIDTH.
  assign taken      = branch & zero;
  assign target     = pc + {branch_imm[ADDR_WIDTH-2:0], 1'b0};
  assign seq_pc     = pc + ADDR_WIDTH'(4);
  assign next_pc    = taken ? target : seq_pc;
  assign misaligned = taken & target[1];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch FSM: requests words from instruction memory, issues them to the
// controller/datapath, and steps the PC from the resolved branch outcome.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter int               ADDR_WIDTH  = 32,
  parameter int               INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int               COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [6:0]             opcode,
  output logic [ADDR_WIDTH-1:0]  pc,
  input  logic                   branch,
  input  logic                   zero,
  input  logic [ADDR_WIDTH-1:0]  branch_imm,
  output logic                   halted,
  output logic                   misaligned_fault,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  // Handshakes: imem_req stays high in FETCH until a cycle with imem_ack=1,
  // which transfers imem_rdata (same-cycle ack allowed). instr_valid is high
  // throughout ISSUE; the cycle with instr_ready=1 transfers the instruction
  // and samples branch/zero/branch_imm. Each side ignores its input outside
  // the state that waits for it.
  fetch_state_t state;

  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  misaligned;

  next_pc_unit #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_next_pc (
    .pc        (pc),
    .branch    (branch),
    .zero      (zero),
    .branch_imm(branch_imm),
    .next_pc   (next_pc),
    .misaligned(misaligned)
  );

  // Request is suppressed in the reset cycle even if state is still FETCH.
  assign imem_req    = (state == FETCH) && !reset;
  assign imem_addr   = pc;
  assign instr_valid = (state == ISSUE);
  assign halted      = (state == HALT);
  assign opcode      = instr[6:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= FETCH;
      pc               <= RESET_PC;
      instr            <= '0;
      misaligned_fault <= 1'b0;
      retired_count    <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ack) begin
            if (imem_rdata == HALT_INSTR[INSTR_WIDTH-1:0]) begin
              state <= HALT;
            end else begin
              instr <= imem_rdata;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            retired_count <= retired_count + COUNT_WIDTH'(1);
            if (misaligned) begin
              misaligned_fault <= 1'b1;
              state            <= HALT;
            end else begin
              pc    <= next_pc;
              state <= FETCH;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios with
// literal expectations plus randomized runs against a transaction-level model.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic        branch;
  logic        zero;
  logic [31:0] branch_imm;
  logic        halted;
  logic        misaligned_fault;
  logic [15:0] retired_count;

  instruction_fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .opcode          (opcode),
    .pc              (pc),
    .branch          (branch),
    .zero            (zero),
    .branch_imm      (branch_imm),
    .halted          (halted),
    .misaligned_fault(misaligned_fault),
    .retired_count   (retired_count)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  // stimulus configuration
  int          cfg_lat;        // -1: random 0..3 wait cycles
  int          cfg_ready_pct;
  int          cfg_br_mode;    // 0: random, 1: branch only on branch opcode
  bit          cfg_zero;
  logic [31:0] cfg_imm;
  bit          cfg_stall_en;
  logic [31:0] cfg_stall_addr;
  bit          cfg_spurious;
  bit          cfg_rand_fill;
  int          cfg_halt_pct;
  bit          cfg_rand_reset;

  logic [31:0] mem [logic [31:0]];
  int          lat_left;

  // behavioural model: pending instruction flag, stopped flag, counters
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_have;
  bit          m_stop;
  bit          m_fault;
  logic [15:0] m_ret;

  // scoreboard logs
  logic [31:0] fetch_log[$];
  int          req_len[$];
  int          cur_run;
  int          valid_count;
  int          req_after_fault;
  logic [6:0]  last_opcode;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [31:0] w;
    if (mem.exists(a)) return mem[a];
    if (cfg_rand_fill) begin
      w = $urandom;
      if (w == 32'h0) w = 32'h1;
      if ($urandom_range(0, 99) < cfg_halt_pct) w = 32'h0;
    end else begin
      w = 32'h00000033;
    end
    mem[a] = w;
    return w;
  endfunction

  task automatic clear_logs();
    fetch_log.delete();
    req_len.delete();
    cur_run = 0;
    valid_count = 0;
    req_after_fault = 0;
    last_opcode = '0;
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, advance the model.
  task automatic step(input bit rst, input bit force_ack);
    bit          a;
    bit          rd;
    bit          b;
    bit          z;
    logic [31:0] d;
    logic [31:0] im;
    logic [31:0] tgt;
    int          v;
    bit          fetching;
    @(negedge clock);
    reset = rst;
    #1;
    fetching = !m_have && !m_stop;
    chk("imem_req", imem_req, fetching && !rst);
    if (fetching) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, m_have);
    if (m_have) begin
      chk("instr", instr, m_instr);
      chk("opcode", opcode, m_instr[6:0]);
    end
    chk("pc", pc, m_pc);
    chk("halted", halted, m_stop && !m_fault ? 1'b1 : m_stop);
    chk("misaligned_fault", misaligned_fault, m_fault);
    chk("retired_count", retired_count, m_ret);
    if (imem_req) cur_run++; else cur_run = 0;
    if (instr_valid) begin
      valid_count++;
      last_opcode = opcode;
    end
    if (misaligned_fault && imem_req) req_after_fault++;

    // memory responder
    a = 1'b0;
    if (imem_req && !(cfg_stall_en && imem_addr == cfg_stall_addr)) begin
      if (lat_left < 0) lat_left = (cfg_lat < 0) ? $urandom_range(0, 3) : cfg_lat;
      if (lat_left == 0) begin
        a = 1'b1;
        lat_left = -1;
      end else begin
        lat_left--;
      end
    end else begin
      lat_left = -1;
      a = cfg_spurious && ($urandom_range(0, 3) == 0);
    end
    if (force_ack) a = 1'b1;
    d = a ? mem_read(imem_addr) : $urandom;

    rd = ($urandom_range(0, 99) < cfg_ready_pct);
    if (cfg_br_mode == 1) begin
      b  = (m_instr[6:0] == 7'b1100011);
      z  = cfg_zero;
      im = cfg_imm;
    end else begin
      b  = $urandom_range(0, 1);
      z  = $urandom_range(0, 1);
      v  = $urandom_range(0, 31) - 16;
      im = 32'(v * 2);
      if ($urandom_range(0, 7) == 0) im = im + 32'd1;
    end
    imem_ack    = a;
    imem_rdata  = d;
    instr_ready = rd;
    branch      = b;
    zero        = z;
    branch_imm  = im;

    @(posedge clock);
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_have = 0; m_stop = 0; m_fault = 0; m_ret = 16'h0;
    end else if (!m_stop) begin
      if (!m_have) begin
        if (a) begin
          fetch_log.push_back(m_pc);
          req_len.push_back(cur_run);
          cur_run = 0;
          if (d == 32'h0) m_stop = 1;
          else begin
            m_instr = d;
            m_have  = 1;
          end
        end
      end else if (rd) begin
        m_ret  = m_ret + 16'd1;
        m_have = 0;
        if (b && z) begin
          tgt = m_pc + im * 2;
          if (tgt % 4 != 0) begin
            m_fault = 1;
            m_stop  = 1;
          end else begin
            m_pc = tgt;
          end
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (cfg_rand_reset && $urandom_range(0, 99) == 0) step(1'b1, 1'b0);
      else step(1'b0, 1'b0);
    end
  endtask

  task automatic directed_cfg();
    mem.delete();
    cfg_lat = 0; cfg_ready_pct = 100; cfg_br_mode = 1; cfg_zero = 0; cfg_imm = 32'h0;
    cfg_stall_en = 0; cfg_stall_addr = 32'h0; cfg_spurious = 0; cfg_rand_fill = 0;
    cfg_halt_pct = 0; cfg_rand_reset = 0;
    lat_left = -1;
    clear_logs();
  endtask

  initial begin
    reset = 1'b1; imem_ack = 0; imem_rdata = '0; instr_ready = 0;
    branch = 0; zero = 0; branch_imm = '0;
    m_pc = 0; m_instr = 0; m_have = 0; m_stop = 0; m_fault = 0; m_ret = 0;

    // zero-wait memory, sequential R-type words, halt word at 0xC
    directed_cfg();
    mem[32'hC] = 32'h0;
    step(1'b1, 1'b0);
    run(12);
    chk("t1_fetch_count", fetch_log.size(), 4);
    if (fetch_log.size() >= 3) begin
      chk("t1_addr0", fetch_log[0], 32'h0);
      chk("t1_addr1", fetch_log[1], 32'h4);
      chk("t1_addr2", fetch_log[2], 32'h8);
    end
    chk("t1_opcode", last_opcode, 7'b0110011);
    chk("t1_valid_cycles", valid_count, 3);
    chk("t1_retired", retired_count, 16'd3);

    // 3-cycle request with ack in the third cycle
    directed_cfg();
    cfg_lat = 2;
    mem[32'h8] = 32'h0;
    step(1'b1, 1'b0);
    run(14);
    chk("t2_req_len0", req_len.size() > 0 ? req_len[0] : -1, 3);
    chk("t2_req_len1", req_len.size() > 1 ? req_len[1] : -1, 3);
    chk("t2_retired", retired_count, 16'd2);

    // BEQ at 0x10, taken back by -16 bytes
    directed_cfg();
    mem[32'h10] = 32'h00000063;
    cfg_zero = 1; cfg_imm = 32'hFFFF_FFF8;
    step(1'b1, 1'b0);
    run(14);
    chk("t3_taken_target", fetch_log.size() > 5 ? fetch_log[5] : 32'hDEAD, 32'h0);

    // same branch, not taken
    directed_cfg();
    mem[32'h10] = 32'h00000063;
    cfg_zero = 0; cfg_imm = 32'hFFFF_FFF8;
    step(1'b1, 1'b0);
    run(14);
    chk("t3_fallthrough", fetch_log.size() > 5 ? fetch_log[5] : 32'hDEAD, 32'h14);

    // taken branch to a half-word target faults
    directed_cfg();
    mem[32'h20] = 32'h00000063;
    cfg_zero = 1; cfg_imm = 32'h1;
    step(1'b1, 1'b0);
    run(26);
    chk("t4_fault", misaligned_fault, 1'b1);
    chk("t4_halted", halted, 1'b1);
    chk("t4_pc", pc, 32'h20);
    chk("t4_req_after_fault", req_after_fault, 0);
    chk("t4_fetch_count", fetch_log.size(), 9);

    // halt word at 0x8 is never issued
    directed_cfg();
    mem[32'h8] = 32'h0;
    step(1'b1, 1'b0);
    run(10);
    chk("t5_halted", halted, 1'b1);
    chk("t5_retired", retired_count, 16'd2);
    chk("t5_valid_cycles", valid_count, 2);
    chk("t5_fault", misaligned_fault, 1'b0);

    // reset while waiting at 0x40, with an ack landing in the reset cycle
    directed_cfg();
    cfg_stall_en = 1; cfg_stall_addr = 32'h40;
    step(1'b1, 1'b0);
    run(40);
    chk("t6_stalled_req", imem_req, 1'b1);
    chk("t6_stalled_addr", imem_addr, 32'h40);
    clear_logs();
    step(1'b1, 1'b1);
    cfg_stall_en = 0;
    #1;
    chk("t6_pc_after_reset", pc, 32'h0);
    chk("t6_valid_after_reset", instr_valid, 1'b0);
    run(4);
    chk("t6_first_fetch", fetch_log.size() > 0 ? fetch_log[0] : 32'hDEAD, 32'h0);

    // randomized runs
    for (int r = 0; r < 20; r++) begin
      directed_cfg();
      cfg_lat = -1; cfg_ready_pct = 60; cfg_br_mode = 0; cfg_spurious = 1;
      cfg_rand_fill = 1; cfg_halt_pct = 2; cfg_rand_reset = 1;
      step(1'b1, 1'b0);
      run(150);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
